// File: rtl/glb_rd_port_master.sv
// GLB read-port initiator: expands a (base, length) command into credit-limited
// word reads and streams the returned words, in order, through a small FIFO.
module glb_rd_port_master #(
  parameter int SRAM_WIDTH = 256,
  parameter int ADDR_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  CfgStart,
  input  logic [ADDR_WIDTH-1:0] CfgBaseAddr,
  input  logic [ADDR_WIDTH-1:0] CfgNumWord,
  output logic                  CfgIdle,
  output logic                  CfgDone,
  output logic [ADDR_WIDTH-1:0] RdPortAddr,
  output logic                  RdPortAddrVld,
  input  logic                  RdPortAddrRdy,
  input  logic [SRAM_WIDTH-1:0] RdPortDat,
  input  logic                  RdPortDatVld,
  output logic                  RdPortDatRdy,
  output logic [SRAM_WIDTH-1:0] OutDat,
  output logic                  OutDatVld,
  input  logic                  OutDatRdy
);

  localparam int CW  = ADDR_WIDTH + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q;
  logic                  cfg_done_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [CW-1:0]         num_q;
  logic [CW-1:0]         issued_q;
  logic [CW-1:0]         recvd_q;
  logic [CW-1:0]         popped_q;

  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [FCW-1:0]        fifo_cnt_q;
  logic [SRAM_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [CW-1:0]         outstanding;
  logic                  addr_vld;
  logic                  addr_fire;
  logic                  dat_rdy;
  logic                  push;
  logic                  out_vld;
  logic                  pop;

  // Everything issued but not yet handed downstream holds a FIFO slot, so
  // issued-popped is exactly inflight + fifo occupancy.
  assign outstanding = issued_q - popped_q;
  assign addr_vld    = (state_q == S_CMD) && (issued_q < num_q)
                       && (outstanding < CW'(FIFO_DEPTH));
  assign addr_fire   = addr_vld && RdPortAddrRdy;
  assign dat_rdy     = (issued_q != recvd_q) && (fifo_cnt_q != FCW'(FIFO_DEPTH));
  assign push        = RdPortDatVld && dat_rdy;
  assign out_vld     = (fifo_cnt_q != '0);
  assign pop         = out_vld && OutDatRdy;

  assign CfgIdle       = (state_q == S_IDLE);
  assign CfgDone       = cfg_done_q;
  assign RdPortAddrVld = addr_vld;
  assign RdPortAddr    = addr_vld ? (base_q + issued_q[ADDR_WIDTH-1:0]) : '0;
  assign RdPortDatRdy  = dat_rdy;
  assign OutDatVld     = out_vld;
  assign OutDat        = out_vld ? mem_q[rd_ptr_q] : '0;

  // NOTE: state registers use non-blocking assignments only, so every branch
  // below reads the pre-edge value of each counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cfg_done_q <= 1'b0;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      recvd_q    <= '0;
      popped_q   <= '0;
    end else begin
      cfg_done_q <= 1'b0;
      if (addr_fire) issued_q <= issued_q + CW'(1);
      if (push)      recvd_q  <= recvd_q + CW'(1);
      if (pop)       popped_q <= popped_q + CW'(1);

      case (state_q)
        S_IDLE: begin
          if (CfgStart) begin
            base_q   <= CfgBaseAddr;
            num_q    <= {1'b0, CfgNumWord};
            issued_q <= '0;
            recvd_q  <= '0;
            popped_q <= '0;
            state_q  <= (CfgNumWord == '0) ? S_DONE : S_CMD;
          end
        end
        S_CMD: begin
          if (addr_fire && (issued_q + CW'(1) == num_q)) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if (pop && (popped_q + CW'(1) == num_q)) state_q <= S_DONE;
        end
        S_DONE: begin
          cfg_done_q <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + FCW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - FCW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // NOTE: the data array is deliberately not reset; OutDat is masked while the
  // FIFO is empty, so stale or unknown entries never reach the consumer.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= RdPortDat;
  end

endmodule

// File: tb/tb_glb_rd_port_master.sv
// Randomized bench for glb_rd_port_master: a latency-varying GLB model and a
// stalling consumer, checked against address/data sequences computed from the command.
module tb_glb_rd_port_master;

  localparam int SW     = 256;
  localparam int AW     = 16;
  localparam int DEPTH  = 4;
  localparam int BUDGET = 3000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          CfgStart;
  logic [AW-1:0] CfgBaseAddr;
  logic [AW-1:0] CfgNumWord;
  logic          CfgIdle;
  logic          CfgDone;
  logic [AW-1:0] RdPortAddr;
  logic          RdPortAddrVld;
  logic          RdPortAddrRdy;
  logic [SW-1:0] RdPortDat;
  logic          RdPortDatVld;
  logic          RdPortDatRdy;
  logic [SW-1:0] OutDat;
  logic          OutDatVld;
  logic          OutDatRdy;

  always #5 clk = ~clk;

  glb_rd_port_master #(.SRAM_WIDTH(SW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .CfgStart(CfgStart), .CfgBaseAddr(CfgBaseAddr), .CfgNumWord(CfgNumWord),
    .CfgIdle(CfgIdle), .CfgDone(CfgDone),
    .RdPortAddr(RdPortAddr), .RdPortAddrVld(RdPortAddrVld), .RdPortAddrRdy(RdPortAddrRdy),
    .RdPortDat(RdPortDat), .RdPortDatVld(RdPortDatVld), .RdPortDatRdy(RdPortDatRdy),
    .OutDat(OutDat), .OutDatVld(OutDatVld), .OutDatRdy(OutDatRdy)
  );

  int n_pass  = 0;
  int n_total = 0;

  int unsigned   salt;
  int            r_issued, r_popped, r_done_pulses, r_done_cycle, r_vld_cycles;
  int            r_max_out, r_hold_issued;
  logic          r_hold_vld;
  bit            r_timeout;
  logic [AW-1:0] r_addr_q[$];

  // Word the GLB holds at a given address for the current command.
  function automatic logic [SW-1:0] word_of(input logic [AW-1:0] a, input int unsigned s);
    logic [31:0] w;
    w = {a ^ s[15:0], ~a};
    return {8{w}};
  endfunction

  // Runs one command end to end: GLB returns data in order after 1..lat_max
  // cycles, consumer is ready ordy_pct% of cycles (never before cycle 'hold').
  task automatic drive_command(input logic [AW-1:0] base, input int num,
                               input int ardy_pct, input int ordy_pct, input int lat_max,
                               input int hold, input int abort_at, input bit noise);
    logic [AW-1:0] glb_addr_q[$];
    int            glb_due_q[$];
    int            cycle = 0;
    int            last_due = 0;
    int            due;
    bit            stall_prev = 0;
    bit            aborting = 0;
    logic [AW-1:0] addr_prev = '0;
    logic [AW-1:0] exp_a;
    logic          av, dv, dr, ov, ar_d, or_d;
    logic [AW-1:0] aa;
    logic [SW-1:0] od;

    salt = $urandom;
    r_issued = 0; r_popped = 0; r_done_pulses = 0; r_done_cycle = -1;
    r_vld_cycles = 0; r_max_out = 0; r_hold_issued = -1; r_hold_vld = 1'bx;
    r_timeout = 0;
    r_addr_q.delete();

    @(posedge clk); #1;
    CfgStart      = 1'b1;
    CfgBaseAddr   = base;
    CfgNumWord    = AW'(num);
    RdPortAddrRdy = ($urandom_range(0, 99) < ardy_pct);
    OutDatRdy     = 1'b0;
    RdPortDatVld  = 1'b0;
    RdPortDat     = '0;

    forever begin
      @(negedge clk);
      av = RdPortAddrVld; aa = RdPortAddr; ar_d = RdPortAddrRdy;
      dv = RdPortDatVld;  dr = RdPortDatRdy;
      ov = OutDatVld;     od = OutDat;      or_d = OutDatRdy;

      if (hold > 0 && cycle == hold) begin
        r_hold_issued = r_issued;
        r_hold_vld    = av;
      end
      if (av === 1'b1) r_vld_cycles++;

      if (stall_prev) begin
        n_total++;
        if (av !== 1'b1 || aa !== addr_prev) begin
          $display("FAIL addr_hold cycle %0d: vld=%b addr=%h, required vld=1 addr=%h",
                   cycle, av, aa, addr_prev);
        end else n_pass++;
      end

      if (dv) begin
        n_total++;
        if (dr !== 1'b1) begin
          $display("FAIL dat_rdy cycle %0d: RdPortDatRdy=%b with data due, required 1", cycle, dr);
        end else n_pass++;
      end

      if (av === 1'b1 && ar_d) begin
        exp_a = base + AW'(r_issued);
        n_total++;
        if (aa !== exp_a) begin
          $display("FAIL addr_seq word %0d: addr=%h, required %h", r_issued, aa, exp_a);
        end else n_pass++;
        r_addr_q.push_back(aa);
        glb_addr_q.push_back(aa);
        due = cycle + int'($urandom_range(1, lat_max));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        glb_due_q.push_back(due);
        r_issued++;
      end
      stall_prev = (av === 1'b1) && !ar_d;
      addr_prev  = aa;

      if (dv && dr === 1'b1) begin
        void'(glb_addr_q.pop_front());
        void'(glb_due_q.pop_front());
      end

      if (ov === 1'b1 && or_d) begin
        n_total++;
        if (od !== word_of(base + AW'(r_popped), salt)) begin
          $display("FAIL out_data word %0d: got %h, required %h", r_popped, od[31:0],
                   word_of(base + AW'(r_popped), salt) >> (SW - 32));
        end else n_pass++;
        r_popped++;
      end
      if (r_issued - r_popped > r_max_out) r_max_out = r_issued - r_popped;

      if (CfgDone === 1'b1) begin
        r_done_pulses++;
        if (r_done_cycle < 0) r_done_cycle = cycle;
      end

      if (abort_at > 0 && r_issued == abort_at) aborting = 1;
      if (r_done_cycle >= 0 && cycle >= r_done_cycle + 3) break;
      if (cycle >= BUDGET) begin
        r_timeout = 1;
        break;
      end

      @(posedge clk); #1;
      cycle++;
      if (aborting) break;

      CfgStart = noise && (r_popped < num) && ($urandom_range(0, 3) == 0);
      if (noise) begin
        CfgBaseAddr = AW'($urandom);
        CfgNumWord  = AW'($urandom);
      end
      RdPortAddrRdy = ($urandom_range(0, 99) < ardy_pct);
      OutDatRdy     = (cycle < hold) ? 1'b0 : ($urandom_range(0, 99) < ordy_pct);
      if (glb_due_q.size() > 0 && glb_due_q[0] <= cycle) begin
        RdPortDatVld = 1'b1;
        RdPortDat    = word_of(glb_addr_q[0], salt);
      end else begin
        RdPortDatVld = 1'b0;
        RdPortDat    = SW'($urandom);
      end
    end

    CfgStart     = 1'b0;
    RdPortDatVld = 1'b0;
    OutDatRdy    = 1'b0;

    if (!aborting) begin
      n_total++;
      if (r_timeout) $display("FAIL cmd_timeout: no CfgDone within %0d cycles", BUDGET);
      else n_pass++;
      n_total++;
      if (r_issued != num || r_popped != num) begin
        $display("FAIL word_count: issued=%0d delivered=%0d, required %0d", r_issued, r_popped, num);
      end else n_pass++;
      n_total++;
      if (r_done_pulses != 1) $display("FAIL done_pulses: %0d, required 1", r_done_pulses);
      else n_pass++;
      n_total++;
      if (CfgIdle !== 1'b1) $display("FAIL idle_after: CfgIdle=%b, required 1", CfgIdle);
      else n_pass++;
      n_total++;
      if (r_max_out > DEPTH) $display("FAIL credit: max outstanding %0d, required <= %0d", r_max_out, DEPTH);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    CfgStart = 1'b0; CfgBaseAddr = '0; CfgNumWord = '0;
    RdPortAddrRdy = 1'b0; RdPortDat = '0; RdPortDatVld = 1'b0; OutDatRdy = 1'b0;
    #23;
    n_total++;
    if ({CfgIdle, CfgDone, RdPortAddrVld, RdPortDatRdy, OutDatVld} !== 5'b10000 ||
        RdPortAddr !== '0 || OutDat !== '0) begin
      $display("FAIL reset_state: idle/done/avld/drdy/ovld=%b%b%b%b%b addr=%h, required 10000 addr=0",
               CfgIdle, CfgDone, RdPortAddrVld, RdPortDatRdy, OutDatVld, RdPortAddr);
    end else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (CfgIdle !== 1'b1 || RdPortAddrVld !== 1'b0) begin
      $display("FAIL post_reset: CfgIdle=%b avld=%b, required 1 0", CfgIdle, RdPortAddrVld);
    end else n_pass++;
  endtask

  task automatic test_basic();
    drive_command(16'h0010, 8, 100, 100, 3, 0, 0, 0);
    n_total++;
    if (r_addr_q.size() != 8 || r_addr_q[0] !== 16'h0010 || r_addr_q[7] !== 16'h0017) begin
      $display("FAIL basic_addrs: count=%0d first=%h last=%h, required 8 0010 0017",
               r_addr_q.size(), r_addr_q[0], r_addr_q[r_addr_q.size() - 1]);
    end else n_pass++;
  endtask

  task automatic test_zero_len();
    drive_command(16'h1234, 0, 100, 100, 2, 0, 0, 0);
    n_total++;
    if (r_vld_cycles != 0) $display("FAIL zero_len_addr: %0d valid cycles, required 0", r_vld_cycles);
    else n_pass++;
    n_total++;
    if (r_done_cycle != 2) $display("FAIL zero_len_done: done at cycle %0d, required 2", r_done_cycle);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    drive_command(16'h0200, 10, 100, 100, 3, 20, 0, 0);
    n_total++;
    if (r_hold_issued != DEPTH || r_hold_vld !== 1'b0) begin
      $display("FAIL credit_stall: issued=%0d avld=%b while blocked, required %0d 0",
               r_hold_issued, r_hold_vld, DEPTH);
    end else n_pass++;
  endtask

  task automatic test_wrap();
    drive_command(16'hFFFE, 4, 100, 100, 2, 0, 0, 0);
    n_total++;
    if (r_addr_q.size() != 4 || r_addr_q[1] !== 16'hFFFF || r_addr_q[2] !== 16'h0000 ||
        r_addr_q[3] !== 16'h0001) begin
      $display("FAIL wrap_addrs: count=%0d a1=%h a2=%h a3=%h, required 4 ffff 0000 0001",
               r_addr_q.size(), r_addr_q[1], r_addr_q[2], r_addr_q[3]);
    end else n_pass++;
  endtask

  task automatic test_random_stalls();
    drive_command(AW'($urandom), 100, 60, 50, 3, 0, 0, 1);
    drive_command(AW'($urandom), 37, 80, 30, 1, 0, 0, 1);
  endtask

  task automatic test_reset_mid_cmd();
    drive_command(16'h0400, 20, 100, 0, 3, 0, 3, 0);
    #1 rst_n = 1'b0;
    #1;
    n_total++;
    if ({CfgIdle, CfgDone, RdPortAddrVld, RdPortDatRdy, OutDatVld} !== 5'b10000 ||
        RdPortAddr !== '0 || OutDat !== '0) begin
      $display("FAIL mid_reset: idle/done/avld/drdy/ovld=%b%b%b%b%b addr=%h, required 10000 addr=0",
               CfgIdle, CfgDone, RdPortAddrVld, RdPortDatRdy, OutDatVld, RdPortAddr);
    end else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_total++;
      if (CfgDone !== 1'b0 || CfgIdle !== 1'b1) begin
        $display("FAIL abort_quiet: CfgDone=%b CfgIdle=%b, required 0 1", CfgDone, CfgIdle);
      end else n_pass++;
    end
    drive_command(16'h0500, 6, 100, 100, 2, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_wrap();
    test_random_stalls();
    test_reset_mid_cmd();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
